frame_buffer_ctrl: RTL and testbench

Ping-pong controller for a dual-bank frame_bram.
- Writer side: accepts a non-stallable pixel stream (camera/processing pipe) into the write bank.
- Reader side: serves display (x,y) reads from the other bank.
- Bank swap: happens only at reader vblank, after a complete frame has been written.
- Sits between the pixel source, the VGA/display pipeline and one frame_bram (LOGSIZE=16, WIDTH=24); the bank select is the BRAM address MSB.

---
 rtl/frame_buffer_pkg.sv | 23 ++
 rtl/frame_addr_calc.sv | 59 +++++
 rtl/frame_buffer_ctrl.sv | 160 ++++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared constants and types for the ping-pong frame buffer controller.
package frame_buffer_pkg;

    localparam int H_PIX        = 160;
    localparam int V_PIX        = 120;
    localparam int LOGSIZE      = 16;
    localparam int WIDTH        = 24;
    localparam int XW           = 8;
    localparam int YW           = 7;
    localparam int FRAME_PIXELS = H_PIX * V_PIX;
    localparam int RD_LAT       = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        FULL_WAIT = 2'd2
    } wr_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_addr_calc.sv
// Registered (x,y) -> {bank, linear address} with out-of-range flag.
module frame_addr_calc
    import frame_buffer_pkg::*;
#(
    parameter int COLS  = H_PIX,
    parameter int ROWS  = V_PIX,
    parameter int XBITS = XW,
    parameter int YBITS = YW,
    parameter int ABITS = LOGSIZE - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [XBITS-1:0] x,
    input  logic [YBITS-1:0] y,
    input  logic             bank,
    input  logic             have_frame,
    output logic [ABITS:0]   addr,
    output logic             re,
    output logic             req,
    output logic             oob
);

    logic [ABITS:0]   addr_q, addr_d;
    logic             re_q, re_d;
    logic             req_q, req_d;
    logic             oob_q, oob_d;
    logic [ABITS-1:0] lin;
    logic             miss;

    always_comb begin
        lin    = ABITS'(y) * ABITS'(COLS) + ABITS'(x);
        miss   = (int'(x) >= COLS) | (int'(y) >= ROWS) | ~have_frame;
        addr_d = en ? {bank, lin} : addr_q;
        re_d   = en & ~miss;
        req_d  = en;
        oob_d  = miss;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            re_q   <= 1'b0;
            req_q  <= 1'b0;
            oob_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            re_q   <= re_d;
            req_q  <= req_d;
            oob_q  <= oob_d;
        end
    end

    assign addr = addr_q;
    assign re   = re_q;
    assign req  = req_q;
    assign oob  = oob_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame buffer: pixel stream into one bank, display reads the other.
module frame_buffer_ctrl
    import frame_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    input  logic               wr_sof,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [XW-1:0]      rd_x,
    input  logic [YW-1:0]      rd_y,
    input  logic               rd_vblank,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_data,
    output logic               frame_ready,
    output logic [7:0]         drop_count,
    output logic               bram_we,
    output logic [LOGSIZE-1:0] bram_wr_addr,
    output logic [WIDTH-1:0]   bram_din,
    output logic               bram_re,
    output logic [LOGSIZE-1:0] bram_rd_addr,
    input  logic [WIDTH-1:0]   bram_dout
);

    localparam int PW = LOGSIZE - 1;
    localparam logic [PW-1:0] LAST = PW'(FRAME_PIXELS - 1);

    wr_state_e          state_q, state_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic               ready_q, ready_d;
    logic [7:0]         drop_q, drop_d;
    logic               we_q, we_d;
    logic [LOGSIZE-1:0] waddr_q, waddr_d;
    logic [WIDTH-1:0]   din_q, din_d;

    logic               s1_req, s1_oob;
    logic               rvld_q, oob2_q;

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_ptr_d  = wr_ptr_q;
        ready_d   = ready_q;
        drop_d    = drop_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        din_d     = din_q;
        unique case (state_q)
            IDLE: begin
                if (wr_valid && wr_sof) begin
                    we_d     = 1'b1;
                    waddr_d  = {wr_bank_q, PW'(0)};
                    din_d    = wr_data;
                    wr_ptr_d = PW'(1);
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (wr_valid) begin
                    we_d  = 1'b1;
                    din_d = wr_data;
                    if (wr_sof) begin
                        // Short frame: restart at pixel 0 of a fresh frame
                        drop_d   = sat_inc8(drop_q);
                        waddr_d  = {wr_bank_q, PW'(0)};
                        wr_ptr_d = PW'(1);
                    end else begin
                        waddr_d = {wr_bank_q, wr_ptr_q};
                        if (wr_ptr_q == LAST) begin
                            state_d = FULL_WAIT;
                        end else begin
                            wr_ptr_d = wr_ptr_q + PW'(1);
                        end
                    end
                end
            end
            FULL_WAIT: begin
                if (wr_valid && wr_sof) begin
                    drop_d = sat_inc8(drop_q);
                end
                if (rd_vblank) begin
                    rd_bank_d = wr_bank_q;
                    wr_bank_d = ~wr_bank_q;
                    ready_d   = 1'b1;
                    wr_ptr_d  = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b1;
            wr_ptr_q  <= '0;
            ready_q   <= 1'b0;
            drop_q    <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_ptr_q  <= wr_ptr_d;
            ready_q   <= ready_d;
            drop_q    <= drop_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            din_q     <= din_d;
        end
    end

    frame_addr_calc #(
        .COLS  (H_PIX),
        .ROWS  (V_PIX),
        .XBITS (XW),
        .YBITS (YW),
        .ABITS (PW)
    ) u_addr (
        .clk        (clk),
        .reset      (reset),
        .en         (rd_en),
        .x          (rd_x),
        .y          (rd_y),
        .bank       (rd_bank_q),
        .have_frame (ready_q),
        .addr       (bram_rd_addr),
        .re         (bram_re),
        .req        (s1_req),
        .oob        (s1_oob)
    );

    // Second stage tracks the BRAM output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvld_q <= 1'b0;
            oob2_q <= 1'b0;
        end else begin
            rvld_q <= s1_req;
            oob2_q <= s1_oob;
        end
    end

    assign rd_valid     = rvld_q;
    assign rd_data      = (rvld_q && !oob2_q) ? bram_dout : '0;
    assign frame_ready  = ready_q;
    assign drop_count   = drop_q;
    assign bram_we      = we_q;
    assign bram_wr_addr = waddr_q;
    assign bram_din     = din_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl with a behavioural frame_bram.
module tb_frame_buffer_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_sof = 1'b0;
    logic [23:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_x = '0;
    logic [6:0]  rd_y = '0;
    logic        rd_vblank = 1'b0;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic        frame_ready;
    logic [7:0]  drop_count;
    logic        bram_we;
    logic [15:0] bram_wr_addr;
    logic [23:0] bram_din;
    logic        bram_re;
    logic [15:0] bram_rd_addr;
    logic [23:0] bram_dout = '0;

    logic [23:0] mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    localparam int F2 = 24'h100000;

    frame_buffer_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_sof       (wr_sof),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_vblank    (rd_vblank),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .frame_ready  (frame_ready),
        .drop_count   (drop_count),
        .bram_we      (bram_we),
        .bram_wr_addr (bram_wr_addr),
        .bram_din     (bram_din),
        .bram_re      (bram_re),
        .bram_rd_addr (bram_rd_addr),
        .bram_dout    (bram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_we) mem[bram_wr_addr] <= bram_din;
        if (bram_re) bram_dout <= mem[bram_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sof, input logic [23:0] d);
        wr_valid = 1'b1;
        wr_sof   = sof;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    task automatic vblank();
        rd_vblank = 1'b1;
        tick();
        rd_vblank = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] x, input logic [6:0] y,
                           input logic exp_re, input logic [15:0] exp_addr,
                           input logic [23:0] exp_data);
        rd_en = 1'b1;
        rd_x  = x;
        rd_y  = y;
        tick();
        rd_en = 1'b0;
        check("bram_re", bram_re, exp_re);
        if (exp_re) check("bram_rd_addr", bram_rd_addr, exp_addr);
        tick();
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, exp_data);
    endtask

    initial begin
        // reset state
        tick();
        check("rst_we", bram_we, 0);
        check("rst_ready", frame_ready, 0);
        check("rst_drop", drop_count, 0);
        check("rst_rvalid", rd_valid, 0);
        reset = 1'b0;
        tick();
        do_read(8'd0, 7'd0, 1'b0, 16'd0, 24'd0);
        check("no_frame_ready", frame_ready, 0);

        // frame 1 into bank 0; vblank alongside the last pixel is ignored
        push(1'b1, 24'd0);
        check("f1_we0", bram_we, 1);
        check("f1_addr0", bram_wr_addr, 0);
        for (int i = 1; i < 19199; i++) push(1'b0, 24'(i));
        rd_vblank = 1'b1;
        push(1'b0, 24'd19199);
        rd_vblank = 1'b0;
        check("f1_addr_last", bram_wr_addr, 19199);
        check("f1_din_last", bram_din, 19199);
        tick();
        check("f1_we_after", bram_we, 0);
        check("vblank_same_cycle", frame_ready, 0);
        vblank();
        check("f1_ready", frame_ready, 1);
        do_read(8'd5, 7'd2, 1'b1, 16'd325, 24'd325);

        // frame 2 into bank 1, then a frame arrives before vblank
        push(1'b1, 24'(F2));
        check("f2_addr0", bram_wr_addr, 32768);
        for (int i = 1; i < 19200; i++) push(1'b0, 24'(F2 + i));
        check("f2_addr_last", bram_wr_addr, 32768 + 19199);
        push(1'b1, 24'd7);
        check("fw_we_sof", bram_we, 0);
        check("fw_drop", drop_count, 1);
        push(1'b0, 24'd8);
        check("fw_we_pix", bram_we, 0);
        vblank();
        do_read(8'd5, 7'd2, 1'b1, 16'(32768 + 325), 24'(F2 + 325));
        push(1'b1, 24'd5000);
        check("f3_we", bram_we, 1);
        check("f3_addr0", bram_wr_addr, 0);
        check("f3_din0", bram_din, 5000);

        // short frame: sof at pixel 100 restarts the frame
        for (int i = 1; i < 100; i++) push(1'b0, 24'd1);
        push(1'b1, 24'd5000);
        check("short_drop", drop_count, 2);
        check("short_addr", bram_wr_addr, 0);
        check("short_we", bram_we, 1);
        for (int i = 1; i < 19200; i++) push(1'b0, 24'(5000 + i));
        check("short_last", bram_wr_addr, 19199);
        push(1'b0, 24'd1);
        check("short_full", bram_we, 0);
        for (int i = 0; i < 300; i++) push(1'b1, 24'd0);
        check("drop_sat", drop_count, 255);
        vblank();

        // back-to-back reads including both out-of-range edges
        rd_en = 1'b1;
        rd_x  = 8'd159;
        rd_y  = 7'd119;
        tick();
        check("bb_re0", bram_re, 1);
        check("bb_addr0", bram_rd_addr, 19199);
        rd_x = 8'd160;
        rd_y = 7'd0;
        tick();
        check("bb_re1", bram_re, 0);
        check("bb_v0", rd_valid, 1);
        check("bb_d0", rd_data, 24199);
        rd_x = 8'd0;
        rd_y = 7'd120;
        tick();
        check("bb_re2", bram_re, 0);
        check("bb_v1", rd_valid, 1);
        check("bb_d1", rd_data, 0);
        rd_en = 1'b0;
        tick();
        check("bb_v2", rd_valid, 1);
        check("bb_d2", rd_data, 0);
        tick();
        check("bb_idle", rd_valid, 0);

        // asynchronous reset in the middle of a frame
        push(1'b1, 24'd9);
        for (int i = 1; i < 500; i++) push(1'b0, 24'd9);
        rd_en = 1'b1;
        rd_x  = 8'd1;
        rd_y  = 7'd1;
        tick();
        rd_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("ar_we", bram_we, 0);
        check("ar_waddr", bram_wr_addr, 0);
        check("ar_din", bram_din, 0);
        check("ar_re", bram_re, 0);
        check("ar_raddr", bram_rd_addr, 0);
        check("ar_rvalid", rd_valid, 0);
        check("ar_rdata", rd_data, 0);
        check("ar_ready", frame_ready, 0);
        check("ar_drop", drop_count, 0);
        #2 reset = 1'b0;
        tick();
        push(1'b0, 24'd3);
        check("ar_idle_ignore", bram_we, 0);
        push(1'b1, 24'd4);
        check("ar_sof_we", bram_we, 1);
        check("ar_sof_addr", bram_wr_addr, 0);
        check("ar_drop_after", drop_count, 0);
        do_read(8'd0, 7'd0, 1'b0, 16'd0, 24'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
